// File: rtl/rpn_stack_controller.sv
// -----------------------------------------------------------------------------
// rpn_stack_controller
//
// Sequencer for the RPN calculator stack datapath. Takes one command at a time
// over a valid/ready handshake and drives the single-port stack RAM (synchronous
// read, one cycle of latency), the stack pointer and an external combinational
// ALU. The top of stack lives in a register (top_value) so the display can show
// it without a RAM read. Overflow and underflow are flagged so the display
// layer can show "Err".
//
// Optional feature: define RPN_CLEAR_EN to add the `clear` input. In IDLE it
// empties the stack, taking priority over a pending command. Without the macro
// the stack is emptied only by reset.
//
// Parameters
//   DATA_W  operand / RAM word width
//   ADDR_W  RAM address width; stack depth is 2**ADDR_W
//
// Ports
//   CLOCK_50       in   sole clock, rising edge
//   reset          in   synchronous, active-high
//   clear          in   (RPN_CLEAR_EN only) empty the stack while idle
//   cmd_valid      in   command present
//   cmd_ready      out  high only while idle
//   cmd_op         in   000 PUSH 001 POP 010 DUP 011 ADD 100 SUB 101 AND 110 OR 111 XOR
//   cmd_data       in   PUSH operand
//   mem_addr       out  RAM address (0 while idle or in error)
//   mem_wdata      out  RAM write data
//   mem_we         out  RAM write enable, forced low while reset is high
//   mem_rdata      in   RAM read data, valid the cycle after mem_addr
//   alu_a          out  second-from-top operand
//   alu_b          out  top operand
//   alu_op         out  latched command opcode
//   alu_result     in   combinational ALU result
//   top_value      out  current top of stack, 0 when empty
//   stack_depth    out  number of entries (the stack pointer)
//   op_done        out  one-cycle pulse on the first idle cycle after a command
//   err_overflow   out  set by a rejected PUSH/DUP, cleared on the next accept
//   err_underflow  out  set by a rejected POP/DUP/binary op, cleared on next accept
// -----------------------------------------------------------------------------
module rpn_stack_controller #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 8
) (
    input  logic              CLOCK_50,
    input  logic              reset,
`ifdef RPN_CLEAR_EN
    input  logic              clear,
`endif
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [2:0]        cmd_op,
    input  logic [DATA_W-1:0] cmd_data,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    output logic [DATA_W-1:0] top_value,
    output logic [ADDR_W:0]   stack_depth,
    output logic              op_done,
    output logic              err_overflow,
    output logic              err_underflow
);

    localparam logic [2:0] OP_PUSH = 3'b000;
    localparam logic [2:0] OP_POP  = 3'b001;
    localparam logic [2:0] OP_DUP  = 3'b010;

    // SP is one bit wider than the address so that a full stack (DEPTH) is
    // representable.
    localparam logic [ADDR_W:0] SP_FULL = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] SP_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] SP_TWO  = (ADDR_W+1)'(2);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ERR,
        S_PUSH_WR,
        S_POP_RD,
        S_POP_LAT,
        S_BIN_RD,
        S_BIN_LAT,
        S_BIN_WR
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W:0]     sp_q, sp_d;
    logic [DATA_W-1:0]   top_q, top_d;
    logic [DATA_W-1:0]   a_q, a_d;
    logic [2:0]          op_q, op_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                ovf_q, ovf_d;
    logic                unf_q, unf_d;
    logic                done_q, done_d;

    logic                clear_req;
    logic                accept;
    logic                need_unf;
    logic                need_ovf;
    logic                we_dec;
    logic [ADDR_W-1:0]   addr_c;
    logic [DATA_W-1:0]   wdata_c;
    logic [ADDR_W-1:0]   addr_second;

`ifdef RPN_CLEAR_EN
    assign clear_req = clear && (state_q == S_IDLE);
`else
    assign clear_req = 1'b0;
`endif

    // A clear in IDLE blocks the handshake so the command waits.
    assign cmd_ready = (state_q == S_IDLE) && !clear_req;
    assign accept    = cmd_valid && cmd_ready;

    // Address of the second-from-top entry (SP-2). The stack's topmost entry
    // is SP-1, mirrored in top_q.
    assign addr_second = sp_q[ADDR_W-1:0] - ADDR_W'(2);

    // Rejection checks on the incoming command; underflow wins over overflow
    // (matters only for DUP, which can hit neither at the same time anyway,
    // but keeps the priority explicit).
    always_comb begin
        need_unf = 1'b0;
        need_ovf = 1'b0;
        case (cmd_op)
            OP_PUSH: need_ovf = (sp_q == SP_FULL);
            OP_POP:  need_unf = (sp_q == '0);
            OP_DUP: begin
                need_unf = (sp_q == '0);
                need_ovf = (sp_q == SP_FULL);
            end
            default: need_unf = (sp_q < SP_TWO);
        endcase
    end

    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        top_d   = top_q;
        a_d     = a_q;
        op_d    = op_q;
        data_d  = data_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        we_dec  = 1'b0;
        addr_c  = '0;
        wdata_c = '0;

        case (state_q)
            S_IDLE: begin
                if (clear_req) begin
                    sp_d  = '0;
                    top_d = '0;
                    ovf_d = 1'b0;
                    unf_d = 1'b0;
                end else if (accept) begin
                    op_d   = cmd_op;
                    data_d = cmd_data;
                    ovf_d  = 1'b0;
                    unf_d  = 1'b0;
                    if (need_unf) begin
                        unf_d   = 1'b1;
                        state_d = S_ERR;
                    end else if (need_ovf) begin
                        ovf_d   = 1'b1;
                        state_d = S_ERR;
                    end else begin
                        case (cmd_op)
                            OP_PUSH, OP_DUP: state_d = S_PUSH_WR;
                            OP_POP:          state_d = S_POP_RD;
                            default:         state_d = S_BIN_RD;
                        endcase
                    end
                end
            end

            S_ERR: begin
                state_d = S_IDLE;
            end

            S_PUSH_WR: begin
                // DUP re-pushes the current top; the RAM copy keeps the
                // "RAM mirrors every entry" invariant used by POP.
                addr_c  = sp_q[ADDR_W-1:0];
                wdata_c = (op_q == OP_DUP) ? top_q : data_q;
                we_dec  = 1'b1;
                sp_d    = sp_q + SP_ONE;
                top_d   = wdata_c;
                state_d = S_IDLE;
            end

            S_POP_RD: begin
                addr_c  = addr_second;
                state_d = S_POP_LAT;
            end

            S_POP_LAT: begin
                // Popping the last entry leaves an empty stack whose top
                // reads as zero; the RAM word fetched from the wrapped
                // address is discarded.
                addr_c  = addr_second;
                top_d   = (sp_q == SP_ONE) ? '0 : mem_rdata;
                sp_d    = sp_q - SP_ONE;
                state_d = S_IDLE;
            end

            S_BIN_RD: begin
                addr_c  = addr_second;
                state_d = S_BIN_LAT;
            end

            S_BIN_LAT: begin
                addr_c  = addr_second;
                a_d     = mem_rdata;
                state_d = S_BIN_WR;
            end

            S_BIN_WR: begin
                // The result replaces the second entry, which becomes the
                // new top after SP drops by one.
                addr_c  = addr_second;
                wdata_c = alu_result;
                we_dec  = 1'b1;
                top_d   = alu_result;
                sp_d    = sp_q - SP_ONE;
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        done_d = ((state_q != S_IDLE) && (state_d == S_IDLE)) || clear_req;
    end

    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_q <= S_IDLE;
            sp_q    <= '0;
            top_q   <= '0;
            a_q     <= '0;
            op_q    <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            top_q   <= top_d;
            a_q     <= a_d;
            op_q    <= op_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
            done_q  <= done_d;
        end
    end

    // PUSH operand latch: only read after an accept has loaded it.
    always_ff @(posedge CLOCK_50) begin
        data_q <= data_d;
    end

    // Gating with reset lets a reset in the middle of an operation abort it
    // without touching the RAM contents.
    assign mem_we        = we_dec && !reset;
    assign mem_addr      = addr_c;
    assign mem_wdata     = wdata_c;

    assign alu_a         = a_q;
    assign alu_b         = top_q;
    assign alu_op        = op_q;

    assign top_value     = top_q;
    assign stack_depth   = sp_q;
    assign op_done       = done_q;
    assign err_overflow  = ovf_q;
    assign err_underflow = unf_q;

endmodule

// File: tb/tb_rpn_stack_controller.sv
// -----------------------------------------------------------------------------
// tb_rpn_stack_controller
//
// Scoreboard bench for rpn_stack_controller with a 4-deep stack (ADDR_W=2).
// The bench provides the stack RAM (synchronous read) and the combinational
// ALU. A reference stack, kept as a queue of integers, predicts every
// command's outcome; the driver pushes the prediction when it issues the
// command and the monitor pops and checks it whenever op_done pulses.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_rpn_stack_controller;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 2;
    localparam int DEPTH  = 4;

    logic              CLOCK_50 = 1'b0;
    logic              reset    = 1'b1;
`ifdef RPN_CLEAR_EN
    logic              clear    = 1'b0;
`endif
    logic              cmd_valid = 1'b0;
    logic              cmd_ready;
    logic [2:0]        cmd_op    = 3'd0;
    logic [DATA_W-1:0] cmd_data  = '0;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;
    logic [DATA_W-1:0] mem_rdata;
    logic [DATA_W-1:0] alu_a;
    logic [DATA_W-1:0] alu_b;
    logic [2:0]        alu_op;
    logic [DATA_W-1:0] alu_result;
    logic [DATA_W-1:0] top_value;
    logic [ADDR_W:0]   stack_depth;
    logic              op_done;
    logic              err_overflow;
    logic              err_underflow;

    rpn_stack_controller #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .CLOCK_50     (CLOCK_50),
        .reset        (reset),
`ifdef RPN_CLEAR_EN
        .clear        (clear),
`endif
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_data     (cmd_data),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_we       (mem_we),
        .mem_rdata    (mem_rdata),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .top_value    (top_value),
        .stack_depth  (stack_depth),
        .op_done      (op_done),
        .err_overflow (err_overflow),
        .err_underflow(err_underflow)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Environment: stack RAM and ALU.
    logic [DATA_W-1:0] ram [DEPTH];
    always @(posedge CLOCK_50) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    always_comb begin
        alu_result = '0;
        case (alu_op)
            3'd3: alu_result = alu_a + alu_b;
            3'd4: alu_result = alu_a - alu_b;
            3'd5: alu_result = alu_a & alu_b;
            3'd6: alu_result = alu_a | alu_b;
            3'd7: alu_result = alu_a ^ alu_b;
            default: alu_result = '0;
        endcase
    end

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    typedef struct {
        int          lat;
        int          top;
        int          depth;
        int          ovf;
        int          unf;
        int          writes;
        int          acc;
        logic [31:0] snap;
    } exp_t;

    typedef struct {
        string name;
        int    act;
        int    exp;
    } req_t;

    exp_t sbq[$];
    req_t rq[$];
    int   stk[$];
    int   total = 0;
    int   bad   = 0;

    function automatic int ref_bin(input int op, input int a, input int b);
        case (op)
            3:       return (a + b) % 256;
            4:       return (a - b + 256) % 256;
            5:       return a & b;
            6:       return a | b;
            default: return a ^ b;
        endcase
    endfunction

    function automatic logic [31:0] pack_stack();
        logic [31:0] r;
        r = '0;
        for (int i = 0; i < stk.size(); i++) r[i*8 +: 8] = 8'(stk[i]);
        return r;
    endfunction

    // Driver-side check request, evaluated by the monitor.
    task automatic chk(input string name, input int act, input int exp);
        req_t r;
        r.name = name;
        r.act  = act;
        r.exp  = exp;
        rq.push_back(r);
    endtask

    task automatic cmpv(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Apply the command to the reference stack and record the prediction.
    task automatic predict(input int op, input int d);
        exp_t e;
        int   a;
        int   b;
        e.lat = 2; e.ovf = 0; e.unf = 0; e.writes = 0; e.acc = cyc;
        case (op)
            0: begin
                if (stk.size() == DEPTH) e.ovf = 1;
                else begin stk.push_back(d); e.writes = 1; end
            end
            1: begin
                if (stk.size() == 0) e.unf = 1;
                else begin void'(stk.pop_back()); e.lat = 3; end
            end
            2: begin
                if (stk.size() == 0) e.unf = 1;
                else if (stk.size() == DEPTH) e.ovf = 1;
                else begin stk.push_back(stk[$]); e.writes = 1; end
            end
            default: begin
                if (stk.size() < 2) e.unf = 1;
                else begin
                    b = stk.pop_back();
                    a = stk.pop_back();
                    stk.push_back(ref_bin(op, a, b));
                    e.lat = 4;
                    e.writes = 1;
                end
            end
        endcase
        e.depth = stk.size();
        e.top   = (stk.size() == 0) ? 0 : stk[$];
        e.snap  = pack_stack();
        sbq.push_back(e);
    endtask

    // Waits for cmd_ready, toggling junk commands while the DUT is busy,
    // then presents one real command for exactly one accepting edge.
    task automatic issue(input int op, input int d);
        int n;
        n = 0;
        @(negedge CLOCK_50);
        while (!cmd_ready && n < 20) begin
            cmd_valid = 1'($urandom_range(0, 1));
            cmd_op    = 3'($urandom_range(0, 7));
            cmd_data  = 8'($urandom_range(0, 255));
            n++;
            @(negedge CLOCK_50);
        end
        if (!cmd_ready) begin
            cmd_valid = 1'b0;
            chk("ready_timeout", 0, 1);
        end else begin
            cmd_valid = 1'b1;
            cmd_op    = 3'(op);
            cmd_data  = 8'(d);
            predict(op, d);
            @(posedge CLOCK_50);
            #1 cmd_valid = 1'b0;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((sbq.size() != 0 || rq.size() != 0) && n < 60) begin
            @(negedge CLOCK_50);
            n++;
        end
        if (n >= 60) chk("drain_timeout", 0, 1);
    endtask

    initial begin : monitor
        exp_t        m;
        req_t        r;
        int          wcount;
        logic [31:0] ram_now;
        wcount = 0;
        forever begin
            @(negedge CLOCK_50);
            if (reset) begin
                wcount = 0;
            end else begin
                if (mem_we) wcount++;
                if (cmd_ready) cmpv("idle_addr", int'(mem_addr), 0);
                if (op_done) begin
                    if (sbq.size() == 0) begin
                        cmpv("spurious_op_done", 1, 0);
                    end else begin
                        m = sbq.pop_front();
                        ram_now = '0;
                        for (int i = 0; i < DEPTH; i++)
                            if (i < m.depth) ram_now[i*8 +: 8] = ram[i];
                        cmpv("latency",   cyc - m.acc,            m.lat);
                        cmpv("top_value", int'(top_value),        m.top);
                        cmpv("depth",     int'(stack_depth),      m.depth);
                        cmpv("err_ovf",   int'(err_overflow),     m.ovf);
                        cmpv("err_unf",   int'(err_underflow),    m.unf);
                        cmpv("ram_writes", wcount,                m.writes);
                        cmpv("ram_image", int'(ram_now),          int'(m.snap));
                    end
                    wcount = 0;
                end
            end
            while (rq.size() != 0) begin
                r = rq.pop_front();
                cmpv(r.name, r.act, r.exp);
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL global_timeout got=running want=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin : driver
        int r;
        int op;

        reset = 1'b1;
        repeat (3) @(negedge CLOCK_50);
        chk("rst_ready",   int'(cmd_ready),     1);
        chk("rst_depth",   int'(stack_depth),   0);
        chk("rst_top",     int'(top_value),     0);
        chk("rst_ovf",     int'(err_overflow),  0);
        chk("rst_unf",     int'(err_underflow), 0);
        chk("rst_done",    int'(op_done),       0);
        chk("rst_we",      int'(mem_we),        0);
        chk("rst_alu_a",   int'(alu_a),         0);
        reset = 1'b0;

        // PUSH 5, PUSH 3, ADD
        issue(0, 5); issue(0, 3); issue(3, 0);
        drain();
        chk("add_top",   int'(top_value),   8);
        chk("add_depth", int'(stack_depth), 1);
        chk("add_ram0",  int'(ram[0]),      8);

        // Popping the last entry empties the stack
        issue(1, 0);
        drain();
        chk("pop_last_top",   int'(top_value),   0);
        chk("pop_last_depth", int'(stack_depth), 0);

        // PUSH 2, PUSH 7, SUB wraps
        issue(0, 2); issue(0, 7); issue(4, 0);
        drain();
        chk("sub_top",   int'(top_value),   8'hFB);
        chk("sub_depth", int'(stack_depth), 1);

        // Underflow on empty stack, cleared by the next accept
        issue(1, 0); issue(1, 0);
        drain();
        chk("empty_pop_unf",   int'(err_underflow), 1);
        chk("empty_pop_depth", int'(stack_depth),   0);
        issue(0, 1);
        drain();
        chk("unf_cleared", int'(err_underflow), 0);

        // Fill to 4 entries then DUP overflows; POP exposes RAM[2]
        issue(0, 10); issue(0, 11); issue(0, 12); issue(2, 0);
        drain();
        chk("dup_ovf",       int'(err_overflow), 1);
        chk("dup_ovf_depth", int'(stack_depth),  4);
        chk("dup_ovf_top",   int'(top_value),    12);
        issue(1, 0);
        drain();
        chk("pop_after_ovf_top", int'(top_value), 11);

        // Random command stream
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4)       op = 0;
            else if (r == 4) op = 2;
            else if (r == 5) op = 1;
            else             op = $urandom_range(3, 7);
            if ($urandom_range(0, 3) == 0) @(negedge CLOCK_50);
            issue(op, $urandom_range(0, 255));
        end
        drain();

        // Reset during BIN_LAT aborts the write
        @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        reset = 1'b0;
        stk.delete();
        issue(0, 1); issue(0, 2);
        drain();
        @(negedge CLOCK_50);
        cmd_valid = 1'b1;
        cmd_op    = 3'd3;
        @(posedge CLOCK_50);
        #1 cmd_valid = 1'b0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        reset = 1'b1;
        @(negedge CLOCK_50);
        chk("abort_we",    int'(mem_we),      0);
        chk("abort_depth", int'(stack_depth), 0);
        chk("abort_top",   int'(top_value),   0);
        chk("abort_ready", int'(cmd_ready),   1);
        chk("abort_alu_a", int'(alu_a),       0);
        reset = 1'b0;
        stk.delete();
        repeat (2) @(negedge CLOCK_50);
        chk("abort_ram0", int'(ram[0]), 1);
        chk("abort_ram1", int'(ram[1]), 2);
        chk("abort_done", int'(op_done), 0);

`ifdef RPN_CLEAR_EN
        // Clear wins over a simultaneous command
        issue(0, 4); issue(0, 6);
        drain();
        @(negedge CLOCK_50);
        clear     = 1'b1;
        cmd_valid = 1'b1;
        cmd_op    = 3'd0;
        cmd_data  = 8'd9;
        chk("clear_blocks_ready", int'(cmd_ready), 0);
        stk.delete();
        begin
            exp_t e;
            e.lat = 1; e.top = 0; e.depth = 0; e.ovf = 0; e.unf = 0;
            e.writes = 0; e.acc = cyc; e.snap = '0;
            sbq.push_back(e);
        end
        @(posedge CLOCK_50);
        #1;
        clear     = 1'b0;
        cmd_valid = 1'b0;
        drain();
        chk("clear_depth", int'(stack_depth), 0);
        chk("clear_top",   int'(top_value),   0);
`endif

        drain();
        repeat (2) @(negedge CLOCK_50);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
